qix_nvram_sequencer: RTL

- Owns the hiscore/NVRAM port of the video CPU board: drives nv_addr/nv_wdata/nv_we into the 1KB video-board NVRAM and consumes nv_rdata.
- Fills NVRAM with a default after reset.
- Loads NVRAM from an HPS ioctl download and serves it back on ioctl upload.
- Tracks a dirty flag from CPU NVRAM writes so the top level can trigger a save.

---
 rtl/qix_nvram_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/qix_nvram_sequencer.sv
// NVRAM port sequencer: default fill after reset, HPS image download into NVRAM, upload back to HPS.
// Outputs are registered; upload bytes take 3 cycles per ioctl_rd with ioctl_wait stalling the HPS meanwhile.
module qix_nvram_sequencer #(
    parameter logic [7:0] NV_IDX   = 8'd4,
    parameter int         ADDR_W   = 10,
    parameter logic [7:0] FILL_VAL = 8'h00
) (
    input  logic        clk_20m,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [15:0] nv_addr,
    output logic [7:0]  nv_wdata,
    output logic        nv_we,
    input  logic [7:0]  nv_rdata,
    input  logic        cpu_nv_wr,
    output logic        busy,
    output logic        dirty
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_UPLOAD
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        wdata_nxt;
    logic              we_nxt;
    logic [7:0]        din_nxt;
    logic              wait_nxt;
    logic              dirty_nxt;
    logic              busy_nxt;
    logic [1:0]        fstage, fstage_nxt;   // upload fetch: 0 idle, 1 address out, 2 data returning
    logic              oob, oob_nxt;

    logic dl_sel;
    logic ul_sel;
    logic in_range;

    assign dl_sel   = ioctl_download & (ioctl_index == NV_IDX);
    assign ul_sel   = ioctl_upload & (ioctl_index == NV_IDX);
    assign in_range = (ioctl_addr[24:ADDR_W] == '0);
    assign nv_addr  = {{(16-ADDR_W){1'b0}}, addr_q};

    always_ff @(posedge clk_20m) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            fill_cnt   <= '0;
            addr_q     <= '0;
            nv_wdata   <= 8'h00;
            nv_we      <= 1'b0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            dirty      <= 1'b0;
            busy       <= 1'b1;
            fstage     <= 2'd0;
            oob        <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_cnt   <= fill_cnt_nxt;
            addr_q     <= addr_nxt;
            nv_wdata   <= wdata_nxt;
            nv_we      <= we_nxt;
            ioctl_din  <= din_nxt;
            ioctl_wait <= wait_nxt;
            dirty      <= dirty_nxt;
            busy       <= busy_nxt;
            fstage     <= fstage_nxt;
            oob        <= oob_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        addr_nxt     = addr_q;
        wdata_nxt    = nv_wdata;
        we_nxt       = 1'b0;
        din_nxt      = ioctl_din;
        wait_nxt     = ioctl_wait;
        dirty_nxt    = dirty;
        fstage_nxt   = fstage;
        oob_nxt      = oob;

        case (state)
            ST_INIT: begin
                // A download preempts the fill; unfilled locations keep whatever they held.
                if (dl_sel) begin
                    state_nxt = ST_LOAD;
                end else begin
                    we_nxt       = 1'b1;
                    wdata_nxt    = FILL_VAL;
                    addr_nxt     = fill_cnt;
                    fill_cnt_nxt = fill_cnt + 1'b1;
                    if (&fill_cnt) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                if (dl_sel) begin
                    state_nxt = ST_LOAD;
                end else if (ul_sel) begin
                    state_nxt = ST_UPLOAD;
                end else if (cpu_nv_wr) begin
                    dirty_nxt = 1'b1;
                end
            end

            ST_LOAD: begin
                if (!dl_sel) begin
                    state_nxt = ST_IDLE;
                    dirty_nxt = 1'b0;
                end else if (ioctl_wr && in_range) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ioctl_addr[ADDR_W-1:0];
                    wdata_nxt = ioctl_dout;
                end
            end

            ST_UPLOAD: begin
                case (fstage)
                    2'd0: begin
                        if (!ul_sel) begin
                            state_nxt = ST_IDLE;
                            dirty_nxt = 1'b0;
                        end else if (ioctl_rd) begin
                            addr_nxt   = ioctl_addr[ADDR_W-1:0];
                            oob_nxt    = !in_range;
                            wait_nxt   = 1'b1;
                            fstage_nxt = 2'd1;
                        end
                    end
                    2'd1: begin
                        fstage_nxt = 2'd2;
                    end
                    default: begin
                        din_nxt    = oob ? 8'h00 : nv_rdata;
                        wait_nxt   = 1'b0;
                        fstage_nxt = 2'd0;
                    end
                endcase
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase

        // busy drops only after a full cycle settled in IDLE, so it trails the last fill write.
        busy_nxt = !((state == ST_IDLE) && (state_nxt == ST_IDLE));
    end

endmodule
